// File: rtl/wdt_pkg.sv
// Shared types and helpers for the watchdog timeout controller.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    INTR  = 2'd2,
    RESET = 2'd3
  } wdt_state_e;

  localparam int RPL_W = 3;

  // Pulse length minus one for a code: 2^(code+1)-1, i.e. 1, 3, ..., 255.
  function automatic logic [7:0] rpl_to_len(input logic [RPL_W-1:0] code);
    logic [8:0] n;
    n = 9'd2 << code;
    return 8'(n - 9'd1);
  endfunction

endpackage

// File: rtl/wdt_rst_pulse.sv
// Reset pulse generator: holds pulse high for 2^(code+1) cycles once started.
module wdt_rst_pulse
  import wdt_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             start,
  input  logic [RPL_W-1:0] rpl_code,
  output logic             pulse,
  output logic             done
);

  logic [7:0] len_q;
  logic       load;

  assign load = start && !pulse;
  assign done = pulse && (len_q == 8'd0);

  always_ff @(posedge pclk) begin
    if (rst) begin
      pulse <= 1'b0;
    end else if (load) begin
      pulse <= 1'b1;
    end else if (done) begin
      pulse <= 1'b0;
    end
  end

  // The length is captured once at start, so later code changes cannot shorten the pulse.
  always_ff @(posedge pclk) begin
    if (load) begin
      len_q <= rpl_to_len(rpl_code);
    end else if (pulse && (len_q != 8'd0)) begin
      len_q <= len_q - 8'd1;
    end
  end

endmodule

// File: rtl/wdt_timeout_ctrl.sv
// Watchdog down-counter and response FSM driving the interrupt and system reset pulse.
module wdt_timeout_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned HC_RPL      = 0,
  parameter int unsigned RPL_DEFAULT = 3
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             wdt_en,
  input  logic [CNT_W-1:0] top_val,
  input  logic             rmod,
  input  logic [RPL_W-1:0] rpl,
  input  logic             restart,
  input  logic             intr_clr,
  output logic             wdt_intr,
  output logic             wdt_rst,
  output logic [CNT_W-1:0] cnt
);

  wdt_state_e       state;
  wdt_state_e       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_dec;
  logic             intr_nxt;
  logic             pulse_start;
  logic             pulse_done;
  logic             timeout;
  logic [RPL_W-1:0] rpl_code;

  assign timeout  = (cnt == '0);
  assign cnt_dec  = cnt - CNT_W'(1);
  assign rpl_code = (HC_RPL != 0) ? RPL_W'(RPL_DEFAULT) : rpl;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wdt_intr <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wdt_intr <= intr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    intr_nxt    = wdt_intr;
    pulse_start = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        intr_nxt = 1'b0;
        if (wdt_en) begin
          state_nxt = COUNT;
          cnt_nxt   = top_val;
        end
      end
      COUNT: begin
        if (!wdt_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          intr_nxt  = 1'b0;
        end else if (restart) begin
          cnt_nxt = top_val;
        end else if (timeout) begin
          if (rmod) begin
            state_nxt = INTR;
            intr_nxt  = 1'b1;
            cnt_nxt   = top_val;
          end else begin
            state_nxt   = RESET;
            pulse_start = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      INTR: begin
        if (!wdt_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          intr_nxt  = 1'b0;
        end else if (restart) begin
          state_nxt = COUNT;
          cnt_nxt   = top_val;
          intr_nxt  = 1'b0;
        end else if (intr_clr && timeout) begin
          // A clear racing a timeout is treated as a fresh first timeout.
          cnt_nxt = top_val;
        end else if (intr_clr) begin
          state_nxt = COUNT;
          intr_nxt  = 1'b0;
          cnt_nxt   = cnt_dec;
        end else if (timeout && wdt_intr) begin
          state_nxt   = RESET;
          pulse_start = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      RESET: begin
        if (pulse_done) begin
          intr_nxt = 1'b0;
          if (wdt_en) begin
            state_nxt = COUNT;
            cnt_nxt   = top_val;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        intr_nxt  = 1'b0;
      end
    endcase
  end

  wdt_rst_pulse u_pulse (
    .pclk     (pclk),
    .rst      (rst),
    .start    (pulse_start),
    .rpl_code (rpl_code),
    .pulse    (wdt_rst),
    .done     (pulse_done)
  );

endmodule

// File: tb/tb_wdt_timeout_ctrl.sv
// Bench for wdt_timeout_ctrl: directed scenarios plus random stimulus against a reference model.
module tb_wdt_timeout_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        wdt_en;
  logic [31:0] top_val;
  logic        rmod;
  logic [2:0]  rpl;
  logic        restart;
  logic        intr_clr;
  logic        wdt_intr, wdt_rst;
  logic [31:0] cnt;
  logic        hc_intr, hc_rst;
  logic [31:0] hc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per instance: index 0 = programmable RPL, 1 = hard-coded RPL of 3.
  logic [31:0] m_cnt [2];
  logic        m_intr[2];
  logic        m_on  [2];
  int          m_left[2];

  wdt_timeout_ctrl #(.CNT_W(32), .HC_RPL(0), .RPL_DEFAULT(3)) dut (
    .pclk(pclk), .rst(rst), .wdt_en(wdt_en), .top_val(top_val), .rmod(rmod),
    .rpl(rpl), .restart(restart), .intr_clr(intr_clr),
    .wdt_intr(wdt_intr), .wdt_rst(wdt_rst), .cnt(cnt)
  );

  wdt_timeout_ctrl #(.CNT_W(32), .HC_RPL(1), .RPL_DEFAULT(3)) dut_hc (
    .pclk(pclk), .rst(rst), .wdt_en(wdt_en), .top_val(top_val), .rmod(rmod),
    .rpl(rpl), .restart(restart), .intr_clr(intr_clr),
    .wdt_intr(hc_intr), .wdt_rst(hc_rst), .cnt(hc_cnt)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got stuck want done");
    $fatal(1, "timeout");
  end

  task automatic model_step(input int k);
    logic [2:0] code;
    if (rst) begin
      m_cnt[k] = 0; m_intr[k] = 0; m_on[k] = 0; m_left[k] = 0;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        m_intr[k] = 0;
        m_on[k]   = wdt_en;
        m_cnt[k]  = wdt_en ? top_val : 32'd0;
      end
    end else if (!m_on[k]) begin
      if (wdt_en) begin m_on[k] = 1; m_cnt[k] = top_val; end
    end else if (!wdt_en) begin
      m_on[k] = 0; m_cnt[k] = 0; m_intr[k] = 0;
    end else if (restart) begin
      m_cnt[k] = top_val; m_intr[k] = 0;
    end else if (m_intr[k] && intr_clr) begin
      if (m_cnt[k] == 0) m_cnt[k] = top_val;
      else begin m_intr[k] = 0; m_cnt[k] = m_cnt[k] - 1; end
    end else if (m_cnt[k] == 0) begin
      if (!m_intr[k] && rmod) begin
        m_intr[k] = 1; m_cnt[k] = top_val;
      end else begin
        code = (k == 1) ? 3'd3 : rpl;
        m_left[k] = 2 << code;
      end
    end else begin
      m_cnt[k] = m_cnt[k] - 1;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic start_run(input logic [31:0] tv, input logic rm, input logic [2:0] rp);
    rst = 1; wdt_en = 0; restart = 0; intr_clr = 0;
    top_val = tv; rmod = rm; rpl = rp;
    tick();
    rst = 0;
    wdt_en = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; wdt_en = 1; restart = 0; intr_clr = 0; top_val = 5; rmod = 0; rpl = 0;
    tick(); tick();
    n_tests++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_tests++; if (wdt_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", wdt_intr); end
    n_tests++; if (wdt_rst !== 1'b0) begin n_fail++; $display("FAIL reset_rst: got %b want 0", wdt_rst); end
    n_tests++; if (hc_cnt !== 32'd0 || hc_rst !== 1'b0 || hc_intr !== 1'b0) begin
      n_fail++; $display("FAIL reset_hc: got cnt %0d rst %b intr %b want 0 0 0", hc_cnt, hc_rst, hc_intr);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    logic exp_rst;
    start_run(32'd5, 1'b0, 3'd0);
    n_tests++; if (cnt !== 32'd5) begin n_fail++; $display("FAIL basic_e0_cnt: got %0d want 5", cnt); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_rst = (k == 6 || k == 7);
      n_tests++; if (wdt_rst !== exp_rst) begin n_fail++; $display("FAIL basic_rst e0+%0d: got %b want %b", k, wdt_rst, exp_rst); end
      if (k == 8) begin
        n_tests++; if (cnt !== 32'd5) begin n_fail++; $display("FAIL basic_reload: got %0d want 5", cnt); end
      end
    end
  endtask

  task automatic test_long_pulse();
    int   hi;
    logic exp_rst;
    hi = 0;
    start_run(32'd3, 1'b0, 3'd7);
    for (int k = 1; k <= 300; k++) begin
      if (k == 50)  rpl = 3'd0;
      if (k == 100) wdt_en = 0;
      if (k == 120) restart = 1;
      if (k == 121) restart = 0;
      tick();
      if (wdt_rst === 1'b1) hi++;
      exp_rst = (k >= 4 && k <= 259);
      n_tests++; if (wdt_rst !== exp_rst) begin n_fail++; $display("FAIL long_rst e0+%0d: got %b want %b", k, wdt_rst, exp_rst); end
    end
    n_tests++; if (hi !== 256) begin n_fail++; $display("FAIL long_len: got %0d want 256", hi); end
    n_tests++; if (cnt !== 32'd0 || wdt_intr !== 1'b0) begin
      n_fail++; $display("FAIL long_idle: got cnt %0d intr %b want 0 0", cnt, wdt_intr);
    end
  endtask

  task automatic test_intr_mode();
    logic exp_i, exp_r;
    start_run(32'd4, 1'b1, 3'd1);
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_i = (k >= 5 && k <= 13);
      exp_r = (k >= 10 && k <= 13);
      n_tests++; if (wdt_intr !== exp_i) begin n_fail++; $display("FAIL intr_noclr_intr e0+%0d: got %b want %b", k, wdt_intr, exp_i); end
      n_tests++; if (wdt_rst !== exp_r) begin n_fail++; $display("FAIL intr_noclr_rst e0+%0d: got %b want %b", k, wdt_rst, exp_r); end
    end
    start_run(32'd4, 1'b1, 3'd1);
    for (int k = 1; k <= 14; k++) begin
      intr_clr = (k == 7);
      tick();
      exp_i = (k >= 5 && k <= 6) || (k >= 10);
      n_tests++; if (wdt_intr !== exp_i) begin n_fail++; $display("FAIL intr_clr_intr e0+%0d: got %b want %b", k, wdt_intr, exp_i); end
      n_tests++; if (wdt_rst !== 1'b0) begin n_fail++; $display("FAIL intr_clr_rst e0+%0d: got %b want 0", k, wdt_rst); end
    end
    intr_clr = 0;
  endtask

  task automatic test_restart();
    start_run(32'd4, 1'b0, 3'd0);
    for (int k = 1; k <= 100; k++) begin
      restart = (k % 3 == 0);
      tick();
      n_tests++; if (wdt_rst !== 1'b0 || wdt_intr !== 1'b0) begin
        n_fail++; $display("FAIL kick_quiet e0+%0d: got rst %b intr %b want 0 0", k, wdt_rst, wdt_intr);
      end
    end
    restart = 0;
    for (int i = 0; i < 10 && cnt !== 32'd0; i++) tick();
    n_tests++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL kick_reach_zero: got %0d want 0", cnt); end
    restart = 1;
    tick();
    restart = 0;
    n_tests++; if (cnt !== 32'd4 || wdt_rst !== 1'b0) begin
      n_fail++; $display("FAIL kick_at_zero: got cnt %0d rst %b want 4 0", cnt, wdt_rst);
    end
    tick();
    n_tests++; if (cnt !== 32'd3) begin n_fail++; $display("FAIL kick_after: got %0d want 3", cnt); end
  endtask

  task automatic test_hc_reset();
    int hi;
    start_run(32'd2, 1'b0, 3'd0);
    for (int i = 0; i < 10 && hc_rst !== 1'b1; i++) tick();
    n_tests++; if (hc_rst !== 1'b1) begin n_fail++; $display("FAIL hc_rise1: got %b want 1", hc_rst); end
    hi = 1;
    for (int i = 0; i < 40 && hc_rst === 1'b1; i++) begin
      tick();
      if (hc_rst === 1'b1) hi++;
    end
    n_tests++; if (hi !== 16) begin n_fail++; $display("FAIL hc_len: got %0d want 16", hi); end
    for (int i = 0; i < 10 && hc_rst !== 1'b1; i++) tick();
    n_tests++; if (hc_rst !== 1'b1) begin n_fail++; $display("FAIL hc_rise2: got %b want 1", hc_rst); end
    for (int i = 0; i < 4; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    n_tests++; if (hc_rst !== 1'b0 || hc_cnt !== 32'd0 || hc_intr !== 1'b0) begin
      n_fail++; $display("FAIL hc_mid_rst: got rst %b cnt %0d intr %b want 0 0 0", hc_rst, hc_cnt, hc_intr);
    end
    tick();
    n_tests++; if (hc_rst !== 1'b0 || hc_cnt !== 32'd2) begin
      n_fail++; $display("FAIL hc_after_rst: got rst %b cnt %0d want 0 2", hc_rst, hc_cnt);
    end
  endtask

  task automatic test_random();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      wdt_en   = ($urandom_range(0, 15) != 0);
      restart  = ($urandom_range(0, 7) == 0);
      intr_clr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) rmod = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) top_val = $urandom_range(0, 6);
      rpl = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      tick();
      n_tests++; if (wdt_rst !== (m_left[0] > 0)) begin n_fail++; $display("FAIL rand_rst cyc %0d: got %b want %b", i, wdt_rst, m_left[0] > 0); end
      n_tests++; if (wdt_intr !== m_intr[0]) begin n_fail++; $display("FAIL rand_intr cyc %0d: got %b want %b", i, wdt_intr, m_intr[0]); end
      n_tests++; if (cnt !== m_cnt[0]) begin n_fail++; $display("FAIL rand_cnt cyc %0d: got %0d want %0d", i, cnt, m_cnt[0]); end
      n_tests++; if (hc_rst !== (m_left[1] > 0)) begin n_fail++; $display("FAIL rand_hc_rst cyc %0d: got %b want %b", i, hc_rst, m_left[1] > 0); end
      n_tests++; if (hc_intr !== m_intr[1]) begin n_fail++; $display("FAIL rand_hc_intr cyc %0d: got %b want %b", i, hc_intr, m_intr[1]); end
      n_tests++; if (hc_cnt !== m_cnt[1]) begin n_fail++; $display("FAIL rand_hc_cnt cyc %0d: got %0d want %0d", i, hc_cnt, m_cnt[1]); end
    end
    rst = 0; restart = 0; intr_clr = 0;
  endtask

  initial begin
    rst = 1; wdt_en = 0; top_val = 0; rmod = 0; rpl = 0; restart = 0; intr_clr = 0;
    for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_intr[k] = 0; m_on[k] = 0; m_left[k] = 0; end
    test_reset();
    test_basic();
    test_long_pulse();
    test_intr_mode();
    test_restart();
    test_hc_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wdt_timeout_ctrl.md
Name: wdt_timeout_ctrl

Overview:
- Watchdog counter plus response controller that produces the system reset pulse `wdt_rst` and the watchdog interrupt, both on `pclk`.
- Counts down from a programmed timeout value. Software restarts ("kicks") it. On timeout it either resets immediately or interrupts first.
- The reset pulse width is selected by RPL: 2^(rpl+1) `pclk` cycles, range 2..256. This is the stage that drives the reset-pulse-length checker.

Parameters:
- CNT_W, 32, width of the timeout counter and of `top_val`.
- HC_RPL, 0, when 1 the `rpl` input is ignored and RPL_DEFAULT is used (hard-coded pulse length).
- RPL_DEFAULT, 3, pulse-length code used when HC_RPL=1 (3 = 16 cycles).

Ports:
- pclk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wdt_en  in  1  watchdog enable (level).
- top_val  in  CNT_W  reload value; timeout period is top_val+1 cycles.
- rmod  in  1  response mode: 0 = reset on first timeout; 1 = interrupt first, reset on second timeout.
- rpl  in  3  reset pulse length code: 0..7 gives 2,4,8,...,256 cycles.
- restart  in  1  single-cycle kick; reloads the counter.
- intr_clr  in  1  single-cycle interrupt clear.
- wdt_intr  out  1  watchdog interrupt, registered level.
- wdt_rst  out  1  system reset pulse, registered.
- cnt  out  CNT_W  current counter value.

Behaviour:
- Reset (rst=1 at an edge):
  - state IDLE; cnt=0; wdt_intr=0; wdt_rst=0.
  - Applies mid-pulse too: wdt_rst is 0 after that edge, and no pulse is resumed.
- States: IDLE, COUNT, INTR, RESET. All outputs are registered.
- IDLE:
  - cnt holds 0.
  - If wdt_en=1: go to COUNT and load cnt=top_val.
- COUNT and INTR, common rules:
  - cnt decrements by 1 each cycle.
  - "Timeout" means cnt==0 at the edge.
  - wdt_en=0 goes to IDLE and clears cnt and wdt_intr. This does not apply in RESET.
- COUNT:
  - restart=1: cnt=top_val.
  - Timeout with rmod=0: go to RESET.
  - Timeout with rmod=1: go to INTR, set wdt_intr=1, load cnt=top_val.
- INTR:
  - restart=1: cnt=top_val, wdt_intr=0, go to COUNT.
  - intr_clr=1 without timeout: wdt_intr=0, go to COUNT, no reload.
  - Timeout while wdt_intr=1 and intr_clr=0: go to RESET.
- Priority within a cycle:
  - rst > wdt_en=0 > restart > intr_clr > timeout.
  - Exception: intr_clr and timeout together in INTR count as a fresh first timeout. wdt_intr stays 1, cnt reloads, state stays INTR.
- RESET:
  - On entry, latch the pulse code: rpl_q = HC_RPL ? RPL_DEFAULT : rpl.
  - wdt_rst=1 for exactly 2^(rpl_q+1) cycles, then 0.
  - Changes to rpl during the pulse are ignored.
  - restart, intr_clr and wdt_en are ignored; the pulse is never truncated except by rst.
  - On the last pulse cycle: wdt_intr=0, cnt=top_val. Next state is COUNT if wdt_en=1, else IDLE with cnt=0.
  - Back-to-back pulses are separated by at least top_val+1 low cycles.
- Latency (E0 = the edge at which wdt_en is first sampled 1 in IDLE, no kicks, rmod=0):
  - After E0, cnt=top_val.
  - wdt_rst rises at edge E0+top_val+1 and falls 2^(rpl_q+1) edges later.
  - A $rose(wdt_rst) is always followed by wdt_rst[*N] ##1 !wdt_rst, where N=2^(rpl_q+1).
- Width rules:
  - The pulse counter is 8 bits, loaded with N-1 and decremented to 0; the pulse ends at 0. This supports 256.
  - The cnt decrement never underflows, because a timeout always reloads or leaves the counting states.
- top_val=0: timeout every cycle. It is legal, with no special case.

Decomposition:
- Package wdt_pkg holds:
  - state enum wdt_state_e {IDLE, COUNT, INTR, RESET};
  - localparam RPL_W=3;
  - function rpl_to_len(code), returning an 8-bit N-1 (1, 3, ..., 255).
- Sub-module wdt_rst_pulse:
  - ports: pclk, rst, start, rpl_code[2:0], pulse, done;
  - latches the code on start, drives pulse for N cycles, asserts done on the last cycle.
- The top level keeps the FSM and the down-counter.

Test Plan:
- rmod=0, top_val=5, rpl=0, wdt_en set at E0 -> wdt_rst high edges E0+6..E0+7 (2 cycles), low at E0+8; cnt=5 after E0+8.
- rmod=0, top_val=3, rpl=7 -> wdt_rst high for exactly 256 cycles. Changing rpl to 0 mid-pulse and dropping wdt_en mid-pulse do not shorten it. IDLE follows.
- rmod=1, top_val=4, no clear -> wdt_intr rises at E0+5, wdt_rst rises at E0+10, wdt_intr=0 at the end of the pulse. Repeat with intr_clr at E0+7 -> no reset, wdt_intr=0, re-raised at E0+10.
- restart every 3 cycles with top_val=4 -> wdt_rst and wdt_intr stay 0 for 100 cycles. Restart in the same cycle as cnt==0 -> reload, no timeout.
- HC_RPL=1, RPL_DEFAULT=3, rpl=0 -> pulse length 16. rst asserted at pulse cycle 5 -> wdt_rst=0, cnt=0, state IDLE at the next edge.
